// File: rtl/rf_mult_unit_if.sv
// rf_mult_unit_if: request/operand/write-back bundle between the controller,
// the register-file read/write ports and the iterative multiplier.
// master = controller/register-file side, slave = multiplier.
//   start, a_in, b_in, adr_dest          : request and operands (master -> slave)
//   rf_din, rf_adr, rf_wr                : register-file write port (slave -> master)
//   busy, done, z_flag, c_flag           : status (slave -> master)
interface rf_mult_unit_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              start;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic [ADDR_W-1:0] adr_dest;
   logic [DATA_W-1:0] rf_din;
   logic [ADDR_W-1:0] rf_adr;
   logic              rf_wr;
   logic              busy;
   logic              done;
   logic              z_flag;
   logic              c_flag;

   modport master (
      output start, a_in, b_in, adr_dest,
      input  rf_din, rf_adr, rf_wr, busy, done, z_flag, c_flag
   );

   modport slave (
      input  start, a_in, b_in, adr_dest,
      output rf_din, rf_adr, rf_wr, busy, done, z_flag, c_flag
   );
endinterface

// File: rtl/rf_mult_unit.sv
// rf_mult_unit: iterative unsigned DATA_W x DATA_W shift-add multiplier writing
//   its 2*DATA_W product back to the register file as two byte writes.
// Latency: accept edge 0, writes land at edges DATA_W+1 / DATA_W+2, DONE in the following cycle.
// Backpressure: none; START is only sampled in IDLE and dropped requests are not queued.
// Ports:
//   i_clk    : clock, all state updates on the rising edge
//   i_rst_n  : asynchronous active-low reset
//   io_mul   : rf_mult_unit_if.slave (start/operands in, rf write port and status out)
module rf_mult_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   rf_mult_unit_if.slave io_mul
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_WR_LO = 3'd2,
      S_WR_HI = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [DATA_W-1:0]   r_mcand;
   logic [DATA_W-1:0]   r_mplr;
   logic [ADDR_W-1:0]   r_dest;
   logic [2*DATA_W-1:0] r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rf_din;
   logic [ADDR_W-1:0]   r_rf_adr;
   logic                r_z;
   logic                r_c;

   logic [2*DATA_W-1:0] w_partial;
   logic [2*DATA_W-1:0] w_acc_next;
   logic                w_last;
   logic                w_rf_wr;
   logic                w_busy;
   logic                w_done;

   // Partial product for the current multiplier bit, aligned by the bit index.
   assign w_partial  = {{DATA_W{1'b0}}, r_mcand} << r_cnt;
   assign w_acc_next = r_mplr[0] ? (r_acc + w_partial) : r_acc;
   assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (io_mul.start) w_state_nxt = S_CALC;
         S_CALC:  if (w_last) w_state_nxt = S_WR_LO;
         S_WR_LO: w_state_nxt = S_WR_HI;
         S_WR_HI: w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the state register only
   always_comb begin
      w_rf_wr = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         S_CALC:  w_busy = 1'b1;
         S_WR_LO: begin
            w_busy  = 1'b1;
            w_rf_wr = 1'b1;
         end
         S_WR_HI: begin
            w_busy  = 1'b1;
            w_rf_wr = 1'b1;
         end
         S_FIN:   w_done = 1'b1;
         default: ;
      endcase
   end

   // Datapath. Write data/address are loaded on the edge entering each write
   // state so the register-file port sees only registered values, and they
   // simply hold afterwards.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mcand  <= '0;
         r_mplr   <= '0;
         r_dest   <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_rf_din <= '0;
         r_rf_adr <= '0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_mul.start) begin
                  // Operands are captured once; the result write may later
                  // overwrite the source register without affecting the product.
                  r_mcand <= io_mul.a_in;
                  r_mplr  <= io_mul.b_in;
                  r_dest  <= io_mul.adr_dest;
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            S_CALC: begin
               r_acc  <= w_acc_next;
               r_mplr <= r_mplr >> 1;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_rf_din <= w_acc_next[DATA_W-1:0];
                  r_rf_adr <= r_dest;
                  r_z      <= (w_acc_next == '0);
                  r_c      <= |w_acc_next[2*DATA_W-1:DATA_W];
               end
            end
            S_WR_LO: begin
               r_rf_din <= r_acc[2*DATA_W-1:DATA_W];
               // Wraps modulo the register count: top register spills into register 0.
               r_rf_adr <= r_dest + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign io_mul.rf_din = r_rf_din;
   assign io_mul.rf_adr = r_rf_adr;
   assign io_mul.rf_wr  = w_rf_wr;
   assign io_mul.busy   = w_busy;
   assign io_mul.done   = w_done;
   assign io_mul.z_flag = r_z;
   assign io_mul.c_flag = r_c;

endmodule

// File: tb/tb_rf_mult_unit.sv
// tb_rf_mult_unit: directed-vector bench for rf_mult_unit with a behavioural
//   32 x 8 register file on the write port and a log of every write (edge, address, data).
module tb_rf_mult_unit;

   logic clk;
   logic rst_n;

   rf_mult_unit_if #(.DATA_W(8), .ADDR_W(5)) bus ();

   rf_mult_unit #(.DATA_W(8), .ADDR_W(5)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_mul  (bus)
   );

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int wr_n = 0;
   int wr_k [64];
   logic [4:0] wr_a [64];
   logic [7:0] wr_d [64];
   logic [7:0] rf [32];

   int e0;
   int wb;
   int busy_cnt;
   int done_cnt;
   int done_k;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file and write log
   always @(posedge clk) begin
      edge_cnt = edge_cnt + 1;
      if (bus.rf_wr === 1'b1) begin
         rf[bus.rf_adr] <= bus.rf_din;
         if (wr_n < 64) begin
            wr_k[wr_n] = edge_cnt;
            wr_a[wr_n] = bus.rf_adr;
            wr_d[wr_n] = bus.rf_din;
            wr_n = wr_n + 1;
         end
      end
   end

   task automatic observe(input int n);
      repeat (n) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) begin
            done_cnt++;
            done_k = edge_cnt - e0;
         end
         @(negedge clk);
      end
   endtask

   // Issues a one-cycle START, scrambles the operand inputs right after accept,
   // and watches 13 cycles (k = 0..12) counted from the accepting edge.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [4:0] d);
      wb = wr_n;
      busy_cnt = 0;
      done_cnt = 0;
      done_k = -1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a_in = a;
      bus.b_in = b;
      bus.adr_dest = d;
      @(negedge clk);
      e0 = edge_cnt;
      bus.start = 1'b0;
      bus.a_in = ~a;
      bus.b_in = 8'h5A;
      bus.adr_dest = ~d;
      observe(13);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.a_in = 8'h00;
      bus.b_in = 8'h00;
      bus.adr_dest = 5'd0;
      #2;
      checks++;
      if ({bus.rf_wr, bus.busy, bus.done, bus.z_flag, bus.c_flag} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl got wr/busy/done/z/c=%b exp 00000",
                  {bus.rf_wr, bus.busy, bus.done, bus.z_flag, bus.c_flag});
      end
      checks++;
      if (bus.rf_din !== 8'h00) begin
         errors++;
         $display("FAIL reset_din got %h exp 00", bus.rf_din);
      end
      checks++;
      if (bus.rf_adr !== 5'd0) begin
         errors++;
         $display("FAIL reset_adr got %0d exp 0", bus.rf_adr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.rf_wr !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start got busy=%b wr=%b exp 0/0", bus.busy, bus.rf_wr);
      end
   endtask

   task automatic test_basic;
      run_op(8'd13, 8'd11, 5'd5);
      checks++;
      if (wr_n - wb !== 2) begin
         errors++;
         $display("FAIL basic_nwr got %0d exp 2", wr_n - wb);
      end
      checks++;
      if ({wr_a[wb], wr_d[wb]} !== {5'd5, 8'h8F} || wr_k[wb] - e0 !== 9) begin
         errors++;
         $display("FAIL basic_lo got R%0d=%h @%0d exp R5=8f @9", wr_a[wb], wr_d[wb], wr_k[wb] - e0);
      end
      checks++;
      if ({wr_a[wb+1], wr_d[wb+1]} !== {5'd6, 8'h00} || wr_k[wb+1] - e0 !== 10) begin
         errors++;
         $display("FAIL basic_hi got R%0d=%h @%0d exp R6=00 @10", wr_a[wb+1], wr_d[wb+1], wr_k[wb+1] - e0);
      end
      checks++;
      if (done_cnt !== 1 || done_k !== 10) begin
         errors++;
         $display("FAIL basic_done got cnt=%0d k=%0d exp 1/10", done_cnt, done_k);
      end
      checks++;
      if (busy_cnt !== 10) begin
         errors++;
         $display("FAIL basic_busy got %0d exp 10", busy_cnt);
      end
      checks++;
      if ({bus.z_flag, bus.c_flag} !== 2'b00) begin
         errors++;
         $display("FAIL basic_flags got z/c=%b exp 00", {bus.z_flag, bus.c_flag});
      end
      checks++;
      if (rf[5] !== 8'h8F || rf[6] !== 8'h00) begin
         errors++;
         $display("FAIL basic_rf got R5=%h R6=%h exp 8f/00", rf[5], rf[6]);
      end
   endtask

   task automatic test_zero;
      run_op(8'h00, 8'h7A, 5'd2);
      checks++;
      if (wr_n - wb !== 2 || {wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]} !== {5'd2, 8'h00, 5'd3, 8'h00}) begin
         errors++;
         $display("FAIL zero_wr got n=%0d R%0d=%h R%0d=%h exp 2 R2=00 R3=00",
                  wr_n - wb, wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]);
      end
      checks++;
      if ({bus.z_flag, bus.c_flag} !== 2'b10) begin
         errors++;
         $display("FAIL zero_flags got z/c=%b exp 10", {bus.z_flag, bus.c_flag});
      end
   endtask

   task automatic test_back_to_back;
      wb = wr_n;
      busy_cnt = 0;
      done_cnt = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a_in = 8'd16;
      bus.b_in = 8'd16;
      bus.adr_dest = 5'd10;
      @(negedge clk);
      e0 = edge_cnt;
      bus.a_in = 8'd3;
      bus.b_in = 8'd3;
      for (int k = 0; k < 23; k++) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) done_cnt++;
         if (k == 10) begin
            checks++;
            if (bus.done !== 1'b1 || bus.c_flag !== 1'b1) begin
               errors++;
               $display("FAIL hold_first_done got done=%b c=%b exp 1/1", bus.done, bus.c_flag);
            end
         end
         if (k == 11) begin
            checks++;
            if (bus.busy !== 1'b0) begin
               errors++;
               $display("FAIL hold_idle_gap got busy=%b exp 0", bus.busy);
            end
         end
         if (k == 22) begin
            checks++;
            if (bus.done !== 1'b1) begin
               errors++;
               $display("FAIL hold_second_done got %b exp 1", bus.done);
            end
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt !== 2 || busy_cnt !== 20) begin
         errors++;
         $display("FAIL hold_counts got done=%0d busy=%0d exp 2/20", done_cnt, busy_cnt);
      end
      checks++;
      if (wr_n - wb !== 4) begin
         errors++;
         $display("FAIL hold_nwr got %0d exp 4", wr_n - wb);
      end
      checks++;
      if ({wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]} !== {5'd10, 8'h00, 5'd11, 8'h01}
          || wr_k[wb+1] - e0 !== 10) begin
         errors++;
         $display("FAIL hold_first_wr got R%0d=%h R%0d=%h @%0d exp R10=00 R11=01 @10",
                  wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1], wr_k[wb+1] - e0);
      end
      checks++;
      if ({wr_a[wb+2], wr_d[wb+2], wr_a[wb+3], wr_d[wb+3]} !== {5'd10, 8'h09, 5'd11, 8'h00}
          || wr_k[wb+2] - e0 !== 21) begin
         errors++;
         $display("FAIL hold_second_wr got R%0d=%h R%0d=%h @%0d exp R10=09 R11=00 @21",
                  wr_a[wb+2], wr_d[wb+2], wr_a[wb+3], wr_d[wb+3], wr_k[wb+2] - e0);
      end
   endtask

   task automatic test_wrap;
      run_op(8'hFF, 8'hFF, 5'd31);
      checks++;
      if (wr_n - wb !== 2 || {wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]} !== {5'd31, 8'h01, 5'd0, 8'hFE}) begin
         errors++;
         $display("FAIL wrap_wr got n=%0d R%0d=%h R%0d=%h exp 2 R31=01 R0=fe",
                  wr_n - wb, wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]);
      end
      checks++;
      if ({bus.z_flag, bus.c_flag} !== 2'b01) begin
         errors++;
         $display("FAIL wrap_flags got z/c=%b exp 01", {bus.z_flag, bus.c_flag});
      end
   endtask

   task automatic test_reset_mid;
      wb = wr_n;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a_in = 8'd20;
      bus.b_in = 8'd20;
      bus.adr_dest = 5'd12;
      @(negedge clk);
      e0 = edge_cnt;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.rf_wr, bus.busy, bus.done, bus.z_flag, bus.c_flag} !== 5'b0) begin
         errors++;
         $display("FAIL midrst_ctl got wr/busy/done/z/c=%b exp 00000",
                  {bus.rf_wr, bus.busy, bus.done, bus.z_flag, bus.c_flag});
      end
      checks++;
      if (bus.rf_din !== 8'h00 || bus.rf_adr !== 5'd0) begin
         errors++;
         $display("FAIL midrst_port got din=%h adr=%0d exp 00/0", bus.rf_din, bus.rf_adr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      busy_cnt = 0;
      observe(12);
      checks++;
      if (busy_cnt !== 0 || wr_n !== wb) begin
         errors++;
         $display("FAIL midrst_quiet got busy=%0d writes=%0d exp 0/0", busy_cnt, wr_n - wb);
      end
      run_op(8'd2, 8'd3, 5'd7);
      checks++;
      if (wr_n - wb !== 2 || {wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]} !== {5'd7, 8'h06, 5'd8, 8'h00}) begin
         errors++;
         $display("FAIL midrst_after got n=%0d R%0d=%h R%0d=%h exp 2 R7=06 R8=00",
                  wr_n - wb, wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]);
      end
   endtask

   task automatic test_alias;
      run_op(8'd3, 8'd3, 5'd4);
      checks++;
      if (rf[4] !== 8'h09) begin
         errors++;
         $display("FAIL alias_preload got R4=%h exp 09", rf[4]);
      end
      run_op(rf[4], rf[4], 5'd4);
      checks++;
      if (rf[4] !== 8'h51 || rf[5] !== 8'h00) begin
         errors++;
         $display("FAIL alias_result got R4=%h R5=%h exp 51/00", rf[4], rf[5]);
      end
      checks++;
      if (wr_n - wb !== 2 || wr_a[wb] !== 5'd4 || wr_d[wb] !== 8'h51 || wr_k[wb] - e0 !== 9) begin
         errors++;
         $display("FAIL alias_wr got n=%0d R%0d=%h @%0d exp 2 R4=51 @9",
                  wr_n - wb, wr_a[wb], wr_d[wb], wr_k[wb] - e0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_alias();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
